multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencer for the single-issue MIPS core. It replaces the purely combinational per-instruction decode with a state machine that steps each instruction through fetch, decode, execute, memory and write-back, and handshakes with instruction and data memories that may insert wait states. It sits between the instruction register and the datapath, and drives the same datapath controls as the existing decoder: register write, ALU op, ALU source B, destination select and jump. It adds memory request, IR/PC write and retire strobes.

## Interface
Parameters:
- none. Opcodes, funct codes and `alu_*` encodings come from `mips_para.v`.

Ports:
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `op_i`  in  6  opcode field of the current instruction register.
- `funct_i`  in  6  funct field of the current instruction register.
- `imem_ready_i`  in  1  instruction memory data valid this cycle.
- `dmem_ready_i`  in  1  data memory access complete this cycle.
- `imem_req`  out  1  fetch request.
- `ir_write`  out  1  load the instruction register.
- `pc_write`  out  1  update the PC.
- `jump`  out  1  PC source is the jump target.
- `reg_write`  out  1  register file write enable.
- `reg_dst`  out  1  1 = rd, 0 = rt.
- `alu_srcb`  out  1  1 = sign-extended immediate, 0 = rt.
- `alu_op`  out  4  ALU operation code (`alu_*`).
- `mem_req`  out  1  data memory request.
- `mem_write`  out  1  data memory write (valid only with `mem_req`).
- `mem_to_reg`  out  1  write-back data comes from memory.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `state`  out  3  current state, for debug.
- `illegal`  out  1  sticky illegal-instruction flag. Present only with `MC_ILLEGAL_TRAP_EN`.

## Operation
Instruction classes are latched into a class register in DECODE:
- ALU_R: R_TYPE with funct ADD, SUB, AND, OR, XOR, SLT or SLTU.
- ALU_I: ADDI, ANDI, ORI, XORI, SLTI.
- LOAD: LW.
- STORE: SW.
- JMP: J.
- ILL: everything else.

States (encoding in `mips_para.v`): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH:
  - `imem_req`=1.
  - When `imem_ready_i`=1: `ir_write`=1, `pc_write`=1 (PC+4), go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Latch the class and `alu_op`.
  - JMP: `jump`=1, `pc_write`=1, `retire`=1, go to FETCH.
  - ILL: see Configuration.
  - Any other class: go to EXEC.
- EXEC:
  - Drive `alu_op` and `alu_srcb`. `alu_srcb`=0 for ALU_R, 1 otherwise; LOAD and STORE use `alu_add`.
  - ALU_R or ALU_I: go to WB.
  - LOAD or STORE: go to MEM.
- MEM:
  - `mem_req`=1, `mem_write`=(class==STORE), `alu_op` held.
  - When `dmem_ready_i`=1: STORE sets `retire`=1 and goes to FETCH; LOAD goes to WB.
  - Otherwise hold.
- WB:
  - `reg_write`=1, `reg_dst`=(class==ALU_R), `mem_to_reg`=(class==LOAD), `retire`=1.
  - Go to FETCH.
- HALT: terminal. All strobes are 0; only `rst` leaves it.

Output rules:
- Outputs are a combinational function of the state and the class register.
- `alu_op` defaults to `alu_add` (never X) outside EXEC and MEM.
- `op_i` and `funct_i` are sampled only in DECODE. Changes in other states are ignored.

## Timing
- Reset: `state`=FETCH and class=ILL on the first edge with `rst`=1.
- While `rst`=1, every output is forced to 0, including `imem_req`, `retire` and `illegal`; `alu_op` is 0.
- The first fetch request appears in the cycle after `rst` deasserts.
- With zero-wait memories (ready=1 on first request), cycles per instruction:
  - J: 2.
  - ALU_R, ALU_I, SW: 4.
  - LW: 5.
- Each wait cycle (ready low) adds exactly one cycle and holds all outputs stable.
- A ready input seen outside its matching state (`imem_ready_i` outside FETCH, `dmem_ready_i` outside MEM) is ignored.
- `rst` asserted mid-operation, including while a request is pending in FETCH or MEM: the next edge returns to FETCH with no `retire` and no write. The memory side must drop the abandoned access.
- `retire` is asserted exactly once per completed instruction.

## Configuration
- `MC_ILLEGAL_TRAP_EN` defined:
  - ILL in DECODE goes to HALT and sets `illegal`=1 on that edge.
  - `illegal` stays 1 until reset.
- Not defined:
  - ILL in DECODE is a NOP: `retire`=1, go to FETCH.
  - There is no `illegal` port and no HALT state.

## Structure
- `mips_para.v` gains:
  - state encodings `MC_FETCH`..`MC_HALT`;
  - class encodings `CLS_ALU_R`..`CLS_ILL`;
  - `LW` and `SW` opcodes.
- One sub-module, `insn_class`: a combinational map from `op_i`/`funct_i` to class and `alu_op`, reusing the existing funct/opcode tables.
- The FSM, class register and output logic live in `multicycle_ctrl`.

## Test plan
- ADD (op 0x00, funct 0x20), zero-wait memories:
  - states 0,1,2,4,0;
  - `reg_write`=1 with `reg_dst`=1 only in cycle 4;
  - `alu_op`=`alu_add` in EXEC;
  - one `retire`.
- ORI followed by J, `imem_ready_i` held low for 3 cycles in the ORI fetch:
  - FETCH lasts 4 cycles;
  - ORI write-back has `alu_srcb`=1 and `reg_dst`=0;
  - J gives `jump`=`pc_write`=1 in DECODE, 2 cycles total.
- SW then LW, `dmem_ready_i` delayed 2 cycles:
  - SW holds `mem_req`=`mem_write`=1 for 3 cycles, no `reg_write`, 6 cycles total;
  - LW has `mem_to_reg`=1 and `reg_write`=1 in WB, 7 cycles total.
- Opcode 0x3F:
  - with `MC_ILLEGAL_TRAP_EN`: `state`=5, `illegal`=1, `imem_req` stays 0 for 20 cycles;
  - without it: 2-cycle NOP with `retire`=1.
- `rst` pulsed while in MEM with `mem_req`=1:
  - all outputs are 0 during reset;
  - no `retire` and no `reg_write`;
  - `imem_req`=1 in the first cycle after release.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: states, instruction
// classes, opcode/funct tables and ALU operation codes.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        MC_FETCH  = 3'd0,
        MC_DECODE = 3'd1,
        MC_EXEC   = 3'd2,
        MC_MEM    = 3'd3,
        MC_WB     = 3'd4,
        MC_HALT   = 3'd5
    } mc_state_t;

    typedef enum logic [2:0] {
        CLS_ALU_R = 3'd0,
        CLS_ALU_I = 3'd1,
        CLS_LOAD  = 3'd2,
        CLS_STORE = 3'd3,
        CLS_JMP   = 3'd4,
        CLS_ILL   = 3'd5
    } insn_cls_t;

    localparam logic [5:0] OP_R_TYPE = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    localparam logic [3:0] ALU_AND  = 4'h0;
    localparam logic [3:0] ALU_OR   = 4'h1;
    localparam logic [3:0] ALU_ADD  = 4'h2;
    localparam logic [3:0] ALU_XOR  = 4'h3;
    localparam logic [3:0] ALU_SUB  = 4'h6;
    localparam logic [3:0] ALU_SLT  = 4'h7;
    localparam logic [3:0] ALU_SLTU = 4'h8;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Sequencer-to-datapath/memory bundle; the sequencer is the master side.
// The illegal flag exists only when MC_ILLEGAL_TRAP_EN is defined.
interface multicycle_ctrl_if;
    logic [5:0] op_i;
    logic [5:0] funct_i;
    logic       imem_ready_i;
    logic       dmem_ready_i;
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic       jump;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_srcb;
    logic [3:0] alu_op;
    logic       mem_req;
    logic       mem_write;
    logic       mem_to_reg;
    logic       retire;
    logic [2:0] state;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    modport master (
        input  op_i, funct_i, imem_ready_i, dmem_ready_i,
        output imem_req, ir_write, pc_write, jump, reg_write, reg_dst,
               alu_srcb, alu_op, mem_req, mem_write, mem_to_reg, retire, state
`ifdef MC_ILLEGAL_TRAP_EN
               , illegal
`endif
    );

    modport slave (
        output op_i, funct_i, imem_ready_i, dmem_ready_i,
        input  imem_req, ir_write, pc_write, jump, reg_write, reg_dst,
               alu_srcb, alu_op, mem_req, mem_write, mem_to_reg, retire, state
`ifdef MC_ILLEGAL_TRAP_EN
               , illegal
`endif
    );
endinterface

// File: rtl/multicycle_ctrl_insn_class.sv
// Combinational instruction classifier: opcode/funct to class and ALU op.
// Unrecognised encodings fall into CLS_ILL with a harmless add.
module insn_class
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output insn_cls_t  cls,
    output logic [3:0] alu_op
);
    always_comb begin
        cls    = CLS_ILL;
        alu_op = ALU_ADD;
        case (op_i)
            OP_R_TYPE: begin
                cls = CLS_ALU_R;
                case (funct_i)
                    F_ADD:   alu_op = ALU_ADD;
                    F_SUB:   alu_op = ALU_SUB;
                    F_AND:   alu_op = ALU_AND;
                    F_OR:    alu_op = ALU_OR;
                    F_XOR:   alu_op = ALU_XOR;
                    F_SLT:   alu_op = ALU_SLT;
                    F_SLTU:  alu_op = ALU_SLTU;
                    default: cls    = CLS_ILL;
                endcase
            end
            OP_ADDI: begin cls = CLS_ALU_I; alu_op = ALU_ADD; end
            OP_ANDI: begin cls = CLS_ALU_I; alu_op = ALU_AND; end
            OP_ORI:  begin cls = CLS_ALU_I; alu_op = ALU_OR;  end
            OP_XORI: begin cls = CLS_ALU_I; alu_op = ALU_XOR; end
            OP_SLTI: begin cls = CLS_ALU_I; alu_op = ALU_SLT; end
            OP_LW:   cls = CLS_LOAD;
            OP_SW:   cls = CLS_STORE;
            OP_J:    cls = CLS_JMP;
            default: cls = CLS_ILL;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB with memory wait states.
// Define MC_ILLEGAL_TRAP_EN to trap illegal instructions into HALT with a sticky flag.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input logic               clk,
    input logic               rst,
    multicycle_ctrl_if.master bus
);
    mc_state_t  state_q, state_nxt;
    insn_cls_t  cls_q, dec_cls;
    logic [3:0] alu_op_q, dec_alu_op;

    logic       imem_req, ir_write, pc_write, jump, reg_write, reg_dst;
    logic       alu_srcb, mem_req, mem_write, mem_to_reg, retire;
    logic [3:0] alu_op;

    insn_class u_insn_class (
        .op_i    (bus.op_i),
        .funct_i (bus.funct_i),
        .cls     (dec_cls),
        .alu_op  (dec_alu_op)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MC_FETCH;
            cls_q   <= CLS_ILL;
        end else begin
            state_q <= state_nxt;
            if (state_q == MC_DECODE) cls_q <= dec_cls;
        end
    end

    // ALU op is only consumed in EXEC/MEM, after DECODE has loaded it
    always_ff @(posedge clk) begin
        if (state_q == MC_DECODE) alu_op_q <= dec_alu_op;
    end

    always_comb begin
        state_nxt  = state_q;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        jump       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        alu_srcb   = 1'b0;
        alu_op     = ALU_ADD;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        case (state_q)
            MC_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ready_i) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = MC_DECODE;
                end
            end
            MC_DECODE: begin
                // The class register is loaded on this edge, so decide from the live decode
                case (dec_cls)
                    CLS_JMP: begin
                        jump      = 1'b1;
                        pc_write  = 1'b1;
                        retire    = 1'b1;
                        state_nxt = MC_FETCH;
                    end
                    CLS_ILL: begin
`ifdef MC_ILLEGAL_TRAP_EN
                        state_nxt = MC_HALT;
`else
                        retire    = 1'b1;
                        state_nxt = MC_FETCH;
`endif
                    end
                    default: state_nxt = MC_EXEC;
                endcase
            end
            MC_EXEC: begin
                alu_op    = alu_op_q;
                alu_srcb  = (cls_q != CLS_ALU_R);
                state_nxt = (cls_q == CLS_LOAD || cls_q == CLS_STORE) ? MC_MEM : MC_WB;
            end
            MC_MEM: begin
                mem_req   = 1'b1;
                mem_write = (cls_q == CLS_STORE);
                alu_op    = alu_op_q;
                alu_srcb  = 1'b1;
                if (bus.dmem_ready_i) begin
                    if (cls_q == CLS_STORE) begin
                        retire    = 1'b1;
                        state_nxt = MC_FETCH;
                    end else begin
                        state_nxt = MC_WB;
                    end
                end
            end
            MC_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (cls_q == CLS_ALU_R);
                mem_to_reg = (cls_q == CLS_LOAD);
                alu_srcb   = (cls_q != CLS_ALU_R);
                retire     = 1'b1;
                state_nxt  = MC_FETCH;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            MC_HALT: state_nxt = MC_HALT;
`endif
            default: state_nxt = MC_FETCH;
        endcase
    end

    // Reset silences every output immediately, abandoning any pending access
    assign bus.imem_req   = ~rst & imem_req;
    assign bus.ir_write   = ~rst & ir_write;
    assign bus.pc_write   = ~rst & pc_write;
    assign bus.jump       = ~rst & jump;
    assign bus.reg_write  = ~rst & reg_write;
    assign bus.reg_dst    = ~rst & reg_dst;
    assign bus.alu_srcb   = ~rst & alu_srcb;
    assign bus.alu_op     = rst ? 4'h0 : alu_op;
    assign bus.mem_req    = ~rst & mem_req;
    assign bus.mem_write  = ~rst & mem_write;
    assign bus.mem_to_reg = ~rst & mem_to_reg;
    assign bus.retire     = ~rst & retire;
    assign bus.state      = rst ? 3'd0 : state_q;
`ifdef MC_ILLEGAL_TRAP_EN
    assign bus.illegal    = ~rst & (state_q == MC_HALT);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction timeline model plus
// literal pins on the directed program's cycle-by-cycle behaviour.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    typedef struct packed {
        logic [2:0] state;
        logic       imem_req;
        logic       ir_write;
        logic       pc_write;
        logic       jump;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_srcb;
        logic [3:0] alu_op;
        logic       mem_req;
        logic       mem_write;
        logic       mem_to_reg;
        logic       retire;
        logic       illegal;
    } out_t;

    typedef struct {
        logic       rst;
        logic       ir;
        logic       dr;
        logic [5:0] op;
        logic [5:0] fn;
        out_t       exp;
    } cyc_t;

    localparam logic [5:0] JUNK_OP = 6'h02;
    localparam logic [5:0] JUNK_FN = 6'h20;
    localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_J = 4, C_ILL = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus();
    multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    cyc_t plan_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    out_t exp_cur;
    logic chk_en  = 1'b0;
    int   cyc_cur = 0;
    out_t obs_log[128];
    int   rt_cyc[$];
    out_t dut_o;

`ifdef MC_ILLEGAL_TRAP_EN
    assign dut_o = {bus.state, bus.imem_req, bus.ir_write, bus.pc_write, bus.jump,
                    bus.reg_write, bus.reg_dst, bus.alu_srcb, bus.alu_op, bus.mem_req,
                    bus.mem_write, bus.mem_to_reg, bus.retire, bus.illegal};
`else
    assign dut_o = {bus.state, bus.imem_req, bus.ir_write, bus.pc_write, bus.jump,
                    bus.reg_write, bus.reg_dst, bus.alu_srcb, bus.alu_op, bus.mem_req,
                    bus.mem_write, bus.mem_to_reg, bus.retire, 1'b0};
`endif

    task automatic classify(input logic [5:0] op, input logic [5:0] fn,
                            output int cls, output logic [3:0] alu);
        cls = C_ILL;
        alu = ALU_ADD;
        if (op == OP_R_TYPE) begin
            cls = C_R;
            if      (fn == F_ADD)  alu = ALU_ADD;
            else if (fn == F_SUB)  alu = ALU_SUB;
            else if (fn == F_AND)  alu = ALU_AND;
            else if (fn == F_OR)   alu = ALU_OR;
            else if (fn == F_XOR)  alu = ALU_XOR;
            else if (fn == F_SLT)  alu = ALU_SLT;
            else if (fn == F_SLTU) alu = ALU_SLTU;
            else cls = C_ILL;
        end
        else if (op == OP_ADDI) begin cls = C_I; alu = ALU_ADD; end
        else if (op == OP_ANDI) begin cls = C_I; alu = ALU_AND; end
        else if (op == OP_ORI)  begin cls = C_I; alu = ALU_OR;  end
        else if (op == OP_XORI) begin cls = C_I; alu = ALU_XOR; end
        else if (op == OP_SLTI) begin cls = C_I; alu = ALU_SLT; end
        else if (op == OP_LW)   cls = C_LD;
        else if (op == OP_SW)   cls = C_ST;
        else if (op == OP_J)    cls = C_J;
    endtask

    function automatic out_t idle(input logic [2:0] st);
        out_t o = '0;
        o.state  = st;
        o.alu_op = ALU_ADD;
        return o;
    endfunction

    task automatic push(input logic r, input logic ir, input logic dr,
                        input logic [5:0] op, input logic [5:0] fn, input out_t e);
        cyc_t c;
        c.rst = r; c.ir = ir; c.dr = dr; c.op = op; c.fn = fn; c.exp = e;
        plan_q.push_back(c);
    endtask

    task automatic push_rst();
        push(1'b1, 1'b1, 1'b1, JUNK_OP, JUNK_FN, out_t'(0));
    endtask

    // Expands one instruction into its expected cycle-by-cycle timeline.
    // abort >= 0 asserts reset after that many data-memory wait cycles.
    task automatic plan_insn(input logic [5:0] op, input logic [5:0] fn,
                             input int wi, input int wd, input int abort);
        int cls;
        logic [3:0] alu;
        out_t o;
        classify(op, fn, cls, alu);
        for (int i = 0; i < wi; i++) begin
            o = idle(3'd0); o.imem_req = 1'b1;
            push(1'b0, 1'b0, 1'b1, JUNK_OP, JUNK_FN, o);
        end
        o = idle(3'd0); o.imem_req = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
        push(1'b0, 1'b1, 1'b1, JUNK_OP, JUNK_FN, o);
        o = idle(3'd1);
        if (cls == C_J) begin
            o.jump = 1'b1; o.pc_write = 1'b1; o.retire = 1'b1;
            push(1'b0, 1'b1, 1'b1, op, fn, o);
            return;
        end
        if (cls == C_ILL) begin
`ifdef MC_ILLEGAL_TRAP_EN
            push(1'b0, 1'b1, 1'b1, op, fn, o);
            for (int i = 0; i < 20; i++) begin
                o = idle(3'd5); o.illegal = 1'b1;
                push(1'b0, 1'b1, 1'b1, JUNK_OP, JUNK_FN, o);
            end
`else
            o.retire = 1'b1;
            push(1'b0, 1'b1, 1'b1, op, fn, o);
`endif
            return;
        end
        push(1'b0, 1'b1, 1'b1, op, fn, o);
        o = idle(3'd2); o.alu_op = alu; o.alu_srcb = (cls != C_R);
        push(1'b0, 1'b1, 1'b1, JUNK_OP, JUNK_FN, o);
        if (cls == C_LD || cls == C_ST) begin
            o = idle(3'd3); o.mem_req = 1'b1; o.mem_write = (cls == C_ST);
            o.alu_op = ALU_ADD; o.alu_srcb = 1'b1;
            for (int i = 0; i < wd; i++) begin
                if (i == abort) begin
                    push_rst();
                    return;
                end
                push(1'b0, 1'b1, 1'b0, JUNK_OP, JUNK_FN, o);
            end
            if (cls == C_ST) o.retire = 1'b1;
            push(1'b0, 1'b1, 1'b1, JUNK_OP, JUNK_FN, o);
            if (cls == C_ST) return;
        end
        o = idle(3'd4); o.reg_write = 1'b1; o.reg_dst = (cls == C_R);
        o.mem_to_reg = (cls == C_LD); o.alu_srcb = (cls != C_R); o.retire = 1'b1;
        push(1'b0, 1'b1, 1'b1, JUNK_OP, JUNK_FN, o);
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if (dut_o !== exp_cur) begin
                n_fail++;
                $display("FAIL cycle%0d outputs got=%h exp=%h", cyc_cur, dut_o, exp_cur);
            end
            obs_log[cyc_cur] = dut_o;
            if (dut_o.retire) rt_cyc.push_back(cyc_cur);
        end
    end

    initial begin
        int rt_delta[8];
        int st_add[5];
        rt_delta = '{4, 7, 2, 6, 7, 5, 4, 4};
        st_add   = '{0, 1, 2, 4, 0};
        bus.op_i = JUNK_OP; bus.funct_i = JUNK_FN;
        bus.imem_ready_i = 1'b1; bus.dmem_ready_i = 1'b1;

        push_rst();
        push_rst();
        plan_insn(OP_R_TYPE, F_ADD,  0, 0, -1);
        plan_insn(OP_ORI,    6'h00,  3, 0, -1);
        plan_insn(OP_J,      6'h00,  0, 0, -1);
        plan_insn(OP_SW,     6'h00,  0, 2, -1);
        plan_insn(OP_LW,     6'h00,  0, 2, -1);
        plan_insn(OP_R_TYPE, F_SUB,  1, 0, -1);
        plan_insn(OP_ANDI,   6'h00,  0, 0, -1);
        plan_insn(OP_R_TYPE, F_SLTU, 0, 0, -1);
        plan_insn(OP_LW,     6'h00,  0, 5, 1);
        plan_insn(OP_ADDI,   6'h00,  0, 0, -1);
        plan_insn(6'h3F,     6'h00,  0, 0, -1);
`ifdef MC_ILLEGAL_TRAP_EN
        push_rst();
`endif
        plan_insn(OP_R_TYPE, F_SLT,  0, 0, -1);

        for (int k = 0; k < plan_q.size(); k++) begin
            @(posedge clk);
            #1;
            rst              = plan_q[k].rst;
            bus.imem_ready_i = plan_q[k].ir;
            bus.dmem_ready_i = plan_q[k].dr;
            bus.op_i         = plan_q[k].op;
            bus.funct_i      = plan_q[k].fn;
            exp_cur          = plan_q[k].exp;
            cyc_cur          = k;
            chk_en           = 1'b1;
        end
        @(posedge clk);
        #1 chk_en = 1'b0;

        for (int i = 0; i < 2; i++) check($sformatf("reset_zero_c%0d", i), int'(obs_log[i]), 0);
        for (int i = 0; i < 5; i++) check($sformatf("add_state_c%0d", i + 2), int'(obs_log[i + 2].state), st_add[i]);
        for (int i = 2; i < 5; i++) check($sformatf("add_no_wr_c%0d", i), int'(obs_log[i].reg_write), 0);
        check("add_wb_reg_write", int'(obs_log[5].reg_write), 1);
        check("add_wb_reg_dst",   int'(obs_log[5].reg_dst), 1);
        check("add_exec_alu_op",  int'(obs_log[4].alu_op), 2);
        for (int i = 6; i < 10; i++) check($sformatf("ori_fetch_req_c%0d", i), int'(obs_log[i].imem_req), 1);
        check("ori_wb_srcb",    int'(obs_log[12].alu_srcb), 1);
        check("ori_wb_reg_dst", int'(obs_log[12].reg_dst), 0);
        check("j_jump",         int'(obs_log[14].jump), 1);
        check("j_pc_write",     int'(obs_log[14].pc_write), 1);
        for (int i = 18; i < 21; i++) check($sformatf("sw_mem_wr_c%0d", i), int'(obs_log[i].mem_req & obs_log[i].mem_write), 1);
        for (int i = 15; i < 21; i++) check($sformatf("sw_no_reg_wr_c%0d", i), int'(obs_log[i].reg_write), 0);
        check("lw_wb_mem_to_reg", int'(obs_log[27].mem_to_reg), 1);
        check("lw_wb_reg_write",  int'(obs_log[27].reg_write), 1);
        check("abort_mem_req",    int'(obs_log[44].mem_req), 1);
        check("abort_rst_zero",   int'(obs_log[45]), 0);
        check("abort_refetch",    int'(obs_log[46].imem_req), 1);
`ifdef MC_ILLEGAL_TRAP_EN
        check("ill_state",   int'(obs_log[71].state), 5);
        check("ill_flag",    int'(obs_log[71].illegal), 1);
        for (int i = 52; i < 72; i++) check($sformatf("halt_no_req_c%0d", i), int'(obs_log[i].imem_req), 0);
        check("retire_total", rt_cyc.size(), 10);
`else
        check("ill_nop_retire", int'(obs_log[51].retire), 1);
        check("ill_nop_state",  int'(obs_log[51].state), 1);
        check("retire_total", rt_cyc.size(), 11);
`endif
        if (rt_cyc.size() >= 9) begin
            check("cpi_insn0", rt_cyc[0] - 1, rt_delta[0]);
            for (int i = 1; i < 8; i++) check($sformatf("cpi_insn%0d", i), rt_cyc[i] - rt_cyc[i - 1], rt_delta[i]);
            check("addi_after_abort_retire", rt_cyc[8], 49);
        end else begin
            check("retire_count_for_cpi", rt_cyc.size(), 9);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
